sew_result_unpacker: RTL and testbench
======================================

// Module: sew_result_unpacker
// PURPOSE
//  Write-back end of the multiplier datapath: the inverse of the SEW operand packer.
//  Takes one 64-bit product vector (each element product is 2*SEW wide) from the multiplier.
//  Extracts low half, high half, or full widened results per SEW.
//  Emits them as 32-bit register beats over a valid/ready handshake toward the VRF write port.
// PARAMETERS
//  REG_WIDTH   32  output beat / register width (only 32 supported)
//  PROD_WIDTH  64  product vector width, = 2*REG_WIDTH
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  flush      in   1           synchronous abort; drops held result
//  sew        in   2           00=8b, 01=16b, 10=32b, 11=illegal
//  mode       in   2           00=LOW (vmul), 01=HIGH (vmulh), 10=WIDEN (vwmul), 11=illegal
//  in_valid   in   1           product vector valid
//  in_ready   out  1           unpacker can accept a product this cycle
//  prod_in    in   PROD_WIDTH  element i product at [2*SEW*i +: 2*SEW]
//  out_valid  out  1           out_data valid
//  out_ready  in   1           consumer accepts beat
//  out_data   out  REG_WIDTH   packed result beat
//  out_last   out  1           final beat of current product
//  err        out  1           one-cycle pulse: illegal sew/mode accepted
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, out_valid=0, out_data=0, out_last=0, err=0, held regs=0.
//  sew/mode/prod_in sampled only on accept (in_valid & in_ready); ignored otherwise.
//  FSM states: IDLE, SINGLE, WIDE0, WIDE1.
//   IDLE   --accept, mode LOW/HIGH/illegal--> SINGLE
//   IDLE   --accept, mode WIDEN-->            WIDE0
//   SINGLE --out_ready-->                     IDLE, or SINGLE/WIDE0 if new accept same cycle
//   WIDE0  --out_ready-->                     WIDE1
//   WIDE1  --out_ready-->                     IDLE, or SINGLE/WIDE0 if new accept same cycle
//  in_ready = (state==IDLE) | (out_valid & out_ready & out_last), combinational.
//   Single-beat results sustain 1 product/cycle.
//  Latency: accept at edge N -> out_valid=1 after edge N (registered outputs; no comb in->out path).
//  Extraction (n = 32/SEW elements, element i, SEW bits each):
//   LOW:   out_data[SEW*i +: SEW] = prod_in[2*SEW*i +: SEW]; out_last=1
//   HIGH:  out_data[SEW*i +: SEW] = prod_in[2*SEW*i+SEW +: SEW]; out_last=1
//   WIDEN: beat0 = prod_in[31:0] (out_last=0); beat1 = prod_in[63:32] (out_last=1)
//  Illegal sew or mode: product accepted; single beat out_data=0, out_last=1.
//   err=1 for exactly the cycle after accept.
//  Backpressure: while out_valid & ~out_ready, out_data/out_last held stable; WIDEN upper half held internally.
//  flush: next edge -> IDLE, out_valid=0, out_last=0; an accept in the flush cycle is discarded.
//   flush has priority over all transitions.
//  rst_n deassertion mid-operation: any in-flight product is lost; no partial beat emitted.
// CONFIGURATION
//  SEW_UNPACK_PERF_CNT_EN defined:
//   adds output beat_cnt[15:0], incremented on every out_valid&out_ready, saturating at 16'hFFFF.
//   Reset to 0 by rst_n; flush does not clear it.
//  Undefined: port and counter absent; behaviour otherwise identical.
// TESTING
//  T1 sew=00 LOW, prod_in=64'hAABB_CCDD_1122_3344 -> out_data=32'hBBDD_2244, out_last=1, one cycle after accept.
//  T2 same prod_in, sew=00 HIGH -> 32'hAACC_1133; sew=01 HIGH, prod_in=64'h1111_2222_3333_4444 -> 32'h1111_3333.
//  T3 sew=01 WIDEN, prod_in=64'h1111_2222_3333_4444, out_ready=1
//     -> beat 32'h3333_4444 last=0, then 32'h1111_2222 last=1; in_ready=0 during beat0.
//  T4 sew=10 LOW, prod_in=64'hDEAD_BEEF_0000_0005, out_ready=0 for 3 cycles
//     -> out_data=32'h0000_0005 stable, in_ready=0, then accepted on out_ready=1.
//  T5 4 back-to-back LOW products, out_ready=1 -> 4 consecutive out_valid cycles, in_ready stays 1.
//     With PERF_CNT_EN: beat_cnt=4.
//  T6 WIDEN, flush after beat0 -> out_valid=0 next cycle, no beat1.
//     Then sew=11 -> out_data=0, err pulse 1 cycle.
//     Then rst_n low mid-SINGLE -> all outputs 0 immediately.

Source files
------------

// File: rtl/sew_result_unpacker.sv
// Multiplier write-back unpacker: turns one 64-bit product vector into 32-bit
// VRF register beats. It extracts the low or high half of each element
// product, or emits the full widened result as two beats.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous abort of the held result
//   sew, mode           element width / result kind, sampled on accept
//   in_valid, in_ready  product handshake
//   prod_in             product vector
//   out_valid, out_ready, out_data, out_last   beat handshake
//   err                 one-cycle pulse after an illegal sew/mode is accepted
//   beat_cnt            saturating beat counter, only with SEW_UNPACK_PERF_CNT_EN
module sew_result_unpacker #(
  parameter int REG_WIDTH  = 32,
  parameter int PROD_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [1:0]            sew,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] prod_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  err
`ifdef SEW_UNPACK_PERF_CNT_EN
  ,
  output logic [15:0]           beat_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    WIDE0,
    WIDE1
  } state_t;

  state_t      state;
  logic [31:0] hold_hi;
  logic        accept;
  logic        illegal;
  logic        widen;
  logic [31:0] lo_res;
  logic [31:0] hi_res;
  logic [31:0] single_res;

  // A new product may enter while the last beat of the previous one leaves.
  assign in_ready = (state == IDLE) | (out_valid & out_ready & out_last);
  assign accept   = in_valid & in_ready;
  assign illegal  = (sew == 2'b11) | (mode == 2'b11);
  assign widen    = (mode == 2'b10) & ~illegal;

  always_comb begin
    lo_res = '0;
    hi_res = '0;
    unique case (1'b1)
      (sew == 2'b00): begin
        for (int i = 0; i < 4; i++) begin
          lo_res[8*i +: 8] = prod_in[16*i +: 8];
          hi_res[8*i +: 8] = prod_in[16*i+8 +: 8];
        end
      end
      (sew == 2'b01): begin
        for (int i = 0; i < 2; i++) begin
          lo_res[16*i +: 16] = prod_in[32*i +: 16];
          hi_res[16*i +: 16] = prod_in[32*i+16 +: 16];
        end
      end
      (sew == 2'b10): begin
        lo_res = prod_in[31:0];
        hi_res = prod_in[63:32];
      end
      default: ;
    endcase
  end

  always_comb begin
    single_res = lo_res;
    if (illegal)
      single_res = '0;
    else if (mode == 2'b01)
      single_res = hi_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      hold_hi   <= '0;
    end else begin
      err <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_last  <= 1'b0;
        hold_hi   <= '0;
      end else if (accept) begin
        out_valid <= 1'b1;
        err       <= illegal;
        if (widen) begin
          state    <= WIDE0;
          out_data <= prod_in[31:0];
          hold_hi  <= prod_in[63:32];
          out_last <= 1'b0;
        end else begin
          state    <= SINGLE;
          out_data <= single_res;
          out_last <= 1'b1;
        end
      end else if (out_valid & out_ready) begin
        if (state == WIDE0) begin
          state    <= WIDE1;
          out_data <= hold_hi;
          out_last <= 1'b1;
        end else begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_data  <= '0;
          out_last  <= 1'b0;
        end
      end
    end
  end

`ifdef SEW_UNPACK_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      beat_cnt <= '0;
    else if (out_valid & out_ready & (beat_cnt != 16'hFFFF))
      beat_cnt <= beat_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sew_result_unpacker.sv
// Testbench for sew_result_unpacker: directed steps with a beat scoreboard.
// Expected beats are queued on drive and checked as beats leave the DUT.
module tb_sew_result_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  sew;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] prod_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        err;
`ifdef SEW_UNPACK_PERF_CNT_EN
  logic [15:0] beat_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  sew_result_unpacker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .sew       (sew),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod_in   (prod_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err       (err)
`ifdef SEW_UNPACK_PERF_CNT_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-level reference: bit b belongs to element b/w at offset b%w.
  function automatic logic [31:0] model(input logic [1:0] s,
                                        input logic [1:0] m,
                                        input logic [63:0] p);
    logic [31:0] d;
    int w;
    d = '0;
    if (s != 2'b11 && m != 2'b11) begin
      w = 8 << s;
      for (int b = 0; b < 32; b++)
        d[b] = p[2*w*(b/w) + (b%w) + ((m == 2'b01) ? w : 0)];
    end
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input logic [1:0] m,
                       input logic [63:0] p);
    in_valid = 1'b1;
    sew      = s;
    mode     = m;
    prod_in  = p;
    if (m == 2'b10 && s != 2'b11) begin
      sb.push_back({1'b0, p[31:0]});
      sb.push_back({1'b1, p[63:32]});
    end else begin
      sb.push_back({1'b1, model(s, m, p)});
    end
  endtask

  // Inputs change just after posedge, so this sample matches the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [32:0] e;
      beats++;
      if (sb.size() == 0) begin
        chk("unexpected_beat", {31'd0, out_last, out_data}, 64'h0);
      end else begin
        e = sb.pop_front();
        chk("beat_data", {32'd0, out_data}, {32'd0, e[31:0]});
        chk("beat_last", {63'd0, out_last}, {63'd0, e[32]});
      end
    end
  end

  initial begin
    int b0;
    logic [63:0] p;
    rst_n = 1'b0; flush = 1'b0; sew = 2'b00; mode = 2'b00;
    in_valid = 1'b0; prod_in = '0; out_ready = 1'b0;
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef SEW_UNPACK_PERF_CNT_EN
    chk("rst_beat_cnt", {48'd0, beat_cnt}, 64'd0);
`endif
    rst_n = 1'b1;
    step();

    // T1: 8b LOW
    out_ready = 1'b1;
    drive(2'b00, 2'b00, 64'hAABB_CCDD_1122_3344);
    step();
    in_valid = 1'b0;
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_data", {32'd0, out_data}, 64'hBBDD_2244);
    step();
    chk("t1_idle", {63'd0, out_valid}, 64'd0);

    // T2: 8b HIGH then 16b HIGH back to back
    drive(2'b00, 2'b01, 64'hAABB_CCDD_1122_3344);
    step();
    chk("t2_data0", {32'd0, out_data}, 64'hAACC_1133);
    chk("t2_in_ready", {63'd0, in_ready}, 64'd1);
    drive(2'b01, 2'b01, 64'h1111_2222_3333_4444);
    step();
    in_valid = 1'b0;
    chk("t2_data1", {32'd0, out_data}, 64'h1111_3333);
    step();

    // T3: 16b WIDEN
    drive(2'b01, 2'b10, 64'h1111_2222_3333_4444);
    step();
    in_valid = 1'b0;
    chk("t3_b0", {31'd0, out_last, out_data}, {31'd0, 1'b0, 32'h3333_4444});
    chk("t3_in_ready_b0", {63'd0, in_ready}, 64'd0);
    step();
    chk("t3_b1", {31'd0, out_last, out_data}, {31'd0, 1'b1, 32'h1111_2222});
    step();
    chk("t3_idle", {63'd0, out_valid}, 64'd0);

    // T4: 32b LOW under 3 cycles of backpressure
    out_ready = 1'b0;
    drive(2'b10, 2'b00, 64'hDEAD_BEEF_0000_0005);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_data", {32'd0, out_data}, 64'h5);
      chk("t4_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("t4_in_ready", {63'd0, in_ready}, 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("t4_idle", {63'd0, out_valid}, 64'd0);

    // T5: 4 back-to-back random LOW products
    b0 = beats;
    for (int i = 0; i < 4; i++) begin
      p = {$urandom, $urandom};
      drive(2'(i % 3), 2'b00, p);
      chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
      step();
      chk("t5_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("t5_beats", 64'(beats - b0), 64'd4);
`ifdef SEW_UNPACK_PERF_CNT_EN
    chk("t5_beat_cnt", {48'd0, beat_cnt}, 64'(beats));
`endif

    // T6: WIDEN flushed after beat0
    in_valid = 1'b1; sew = 2'b00; mode = 2'b10;
    prod_in = 64'h0123_4567_89AB_CDEF;
    sb.push_back({1'b0, 32'h89AB_CDEF});
    step();
    in_valid = 1'b0;
    step();
    chk("t6_wide1", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_flush_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_flush_last", {63'd0, out_last}, 64'd0);
    step();
    chk("t6_no_beat1", {63'd0, out_valid}, 64'd0);

    // Accept in the flush cycle is discarded, and no err from it
    flush = 1'b1; in_valid = 1'b1; sew = 2'b11; mode = 2'b00;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_drop_err", {63'd0, err}, 64'd0);

    // Illegal sew, then illegal mode
    out_ready = 1'b1;
    drive(2'b11, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    in_valid = 1'b0;
    chk("ill_sew_err", {63'd0, err}, 64'd1);
    chk("ill_sew_data", {31'd0, out_last, out_data}, {31'd0, 1'b1, 32'h0});
    step();
    chk("ill_sew_err_pulse", {63'd0, err}, 64'd0);
    drive(2'b00, 2'b11, 64'h1234_5678_9ABC_DEF0);
    step();
    in_valid = 1'b0;
    chk("ill_mode_err", {63'd0, err}, 64'd1);
    step();
    chk("ill_mode_err_pulse", {63'd0, err}, 64'd0);

    // Async reset mid-SINGLE drops the product
    out_ready = 1'b0;
    in_valid = 1'b1; sew = 2'b00; mode = 2'b00;
    prod_in = 64'h5555_6666_7777_8888;
    step();
    in_valid = 1'b0;
    chk("mid_single", {63'd0, out_valid}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_valid", {63'd0, out_valid}, 64'd0);
    chk("async_data", {32'd0, out_data}, 64'd0);
    chk("async_last", {63'd0, out_last}, 64'd0);
    chk("async_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
